// File: rtl/cr_kme_fifo_unpack.sv
// Unpacks 132-bit KME staging FIFO entries into one or two 64-bit beats with sot/eot, tag check and packet count.
// Latency: first beat one cycle after the pop; the next entry is popped in the cycle its predecessor's last beat is accepted.
// Backpressure: out_ready low holds the current beat stable and withholds fifo_out_ack.
module cr_kme_fifo_unpack #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [131:0]     fifo_out,
    input  logic             fifo_out_valid,
    output logic             fifo_out_ack,
    output logic [63:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sot,
    output logic             out_eot,
    output logic [1:0]       out_tid,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic             tid_err
);

    typedef struct packed {
        logic [1:0]   tid;
        logic         half;
        logic         eot;
        logic [127:0] payload;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } st_t;

    st_t        st;
    st_t        st_nxt;
    entry_t     hold;
    logic       sot_pend;
    logic [1:0] prev_tid;
    logic       acc;
    logic       last;
    logic       load;

    always_comb begin
        out_valid = (st != IDLE);
        last      = (st == HI) | ((st == LO) & hold.half);
        acc       = out_valid & out_ready;
        // Gated by rst so nothing is popped (and lost) while the block is held in reset.
        load      = fifo_out_valid & ~rst & ((st == IDLE) | (acc & last));

        out_data  = 64'd0;
        out_tid   = 2'd0;
        if (st == LO) begin
            out_data = hold.payload[63:0];
        end else if (st == HI) begin
            out_data = hold.payload[127:64];
        end
        if (out_valid) begin
            out_tid = hold.tid;
        end
        out_eot      = out_valid & last & hold.eot;
        out_sot      = (st == LO) & sot_pend;
        fifo_out_ack = load;
    end

    always_comb begin
        st_nxt = st;
        if (load) begin
            st_nxt = LO;
        end else if (acc & ~last) begin
            st_nxt = HI;
        end else if (acc & last) begin
            st_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st   <= IDLE;
            hold <= '0;
        end else begin
            st <= st_nxt;
            if (load) begin
                hold <= entry_t'(fifo_out);
            end
        end
    end

    // Packet tracking: sot_pend survives FIFO underruns so a resumed packet gets no second sot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sot_pend <= 1'b1;
            prev_tid <= 2'd0;
            pkt_cnt  <= '0;
            tid_err  <= 1'b0;
        end else if (acc) begin
            sot_pend <= out_eot;
            prev_tid <= out_tid;
            if (out_eot) begin
                pkt_cnt <= pkt_cnt + 1'b1;
            end
            if (~out_sot & (out_tid != prev_tid)) begin
                tid_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cr_kme_fifo_unpack.sv
// Scoreboard bench for cr_kme_fifo_unpack: entries expand into expected beats when queued; a monitor checks accepted beats.
module tb_cr_kme_fifo_unpack;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic [131:0]     fifo_out;
    logic             fifo_out_valid;
    logic             fifo_out_ack;
    logic [63:0]      out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_sot;
    logic             out_eot;
    logic [1:0]       out_tid;
    logic [CNT_W-1:0] pkt_cnt;
    logic             tid_err;

    cr_kme_fifo_unpack #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_out       (fifo_out),
        .fifo_out_valid (fifo_out_valid),
        .fifo_out_ack   (fifo_out_ack),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_sot        (out_sot),
        .out_eot        (out_eot),
        .out_tid        (out_tid),
        .pkt_cnt        (pkt_cnt),
        .tid_err        (tid_err)
    );

    typedef struct packed {
        logic [63:0] d;
        logic        sot;
        logic        eot;
        logic [1:0]  tid;
    } beat_t;

    logic [131:0] src_q[$];
    beat_t        exp_q[$];

    int checks   = 0;
    int failures = 0;
    int ready_mode;
    int ack_total = 0;
    int cur_run   = 0;
    int max_run   = 0;

    logic             m_sot;
    logic [CNT_W-1:0] m_cnt;
    logic             m_err;
    logic [1:0]       m_prev;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic m_reset();
        exp_q.delete();
        m_sot  = 1'b1;
        m_cnt  = '0;
        m_err  = 1'b0;
        m_prev = 2'd0;
    endtask

    // Reference: an entry becomes one beat (half) or LO then HI; eot lands on the final beat, sot on the packet's first.
    task automatic push(input logic [1:0] tid, input logic half, input logic eot, input logic [127:0] pl);
        beat_t b;
        if (half) begin
            b = '{d: pl[63:0], sot: m_sot, eot: eot, tid: tid};
            exp_q.push_back(b);
        end else begin
            b = '{d: pl[63:0], sot: m_sot, eot: 1'b0, tid: tid};
            exp_q.push_back(b);
            b = '{d: pl[127:64], sot: 1'b0, eot: eot, tid: tid};
            exp_q.push_back(b);
        end
        m_sot = eot;
        src_q.push_back({tid, half, eot, pl});
    endtask

    function automatic logic [127:0] rnd_pl();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || src_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || src_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d/%0d beats/entries left required=0/0", exp_q.size(), src_q.size());
            exp_q.delete();
            src_q.delete();
        end
        tick();
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (out_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("wait_valid", out_valid, 1);
    endtask

    // FIFO side and downstream ready driver.
    initial begin
        fifo_out       = '0;
        fifo_out_valid = 1'b0;
        out_ready      = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            fifo_out_valid = (src_q.size() > 0);
            fifo_out       = (src_q.size() > 0) ? src_q[0] : {4'h0, rnd_pl()};
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Monitor: compares every accepted beat against the scoreboard and checks hold/idle/latency rules.
    initial begin
        logic        stall_p = 1'b0;
        logic        ack_p   = 1'b0;
        logic [63:0] sd      = '0;
        logic        ss      = 1'b0;
        logic        se      = 1'b0;
        logic [1:0]  st      = '0;
        beat_t       b;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_p = 1'b0;
                ack_p   = 1'b0;
                cur_run = 0;
            end else begin
                if (ack_p) chk("latency_valid", out_valid, 1);
                if (stall_p) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", out_data, sd);
                    chk("hold_sot", out_sot, ss);
                    chk("hold_eot", out_eot, se);
                    chk("hold_tid", out_tid, st);
                end
                if (!out_valid) begin
                    chk("idle_data", out_data, 0);
                    chk("idle_sot", out_sot, 0);
                    chk("idle_eot", out_eot, 0);
                    chk("idle_tid", out_tid, 0);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat actual=%0h required=no beat", out_data);
                    end else begin
                        b = exp_q.pop_front();
                        chk("beat_data", out_data, b.d);
                        chk("beat_sot", out_sot, b.sot);
                        chk("beat_eot", out_eot, b.eot);
                        chk("beat_tid", out_tid, b.tid);
                        chk("pkt_cnt", pkt_cnt, m_cnt);
                        chk("tid_err", tid_err, m_err);
                        if (!b.sot && b.tid != m_prev) m_err = 1'b1;
                        m_prev = b.tid;
                        if (b.eot) m_cnt = m_cnt + 1'b1;
                    end
                end
                if (fifo_out_ack) begin
                    chk("ack_needs_valid", fifo_out_valid, 1);
                    if (src_q.size() > 0) void'(src_q.pop_front());
                    ack_total++;
                    cur_run++;
                    if (cur_run > max_run) max_run = cur_run;
                end else begin
                    cur_run = 0;
                end
                stall_p = out_valid & ~out_ready;
                sd      = out_data;
                ss      = out_sot;
                se      = out_eot;
                st      = out_tid;
                ack_p   = fifo_out_ack;
            end
        end
    end

    initial begin
        int          a0;
        logic [1:0]  cur_tid;
        logic [127:0] pl;
        rst        = 1'b1;
        ready_mode = 1;
        m_reset();
        repeat (3) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_sot", out_sot, 0);
        chk("rst_eot", out_eot, 0);
        chk("rst_tid", out_tid, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_tid_err", tid_err, 0);
        chk("rst_ack", fifo_out_ack, 0);
        rst = 1'b0;
        tick();

        // Single full entry.
        a0 = ack_total;
        push(2'd1, 1'b0, 1'b1, rnd_pl());
        wait_drain(50);
        chk("s1_pkt_cnt", pkt_cnt, 1);
        chk("s1_acks", ack_total - a0, 1);

        // Four back-to-back single-beat packets.
        max_run = 0;
        for (int i = 0; i < 4; i++) push(2'd0, 1'b1, 1'b1, rnd_pl());
        wait_drain(50);
        chk("s2_ack_run", max_run, 4);
        chk("s2_pkt_cnt", pkt_cnt, 5);

        // Backpressure on a full entry with a second entry waiting.
        ready_mode = 0;
        a0 = ack_total;
        push(2'd3, 1'b0, 1'b1, rnd_pl());
        push(2'd3, 1'b1, 1'b1, rnd_pl());
        wait_valid(20);
        repeat (3) tick();
        chk("s3_acks_stalled", ack_total - a0, 1);
        ready_mode = 1;
        wait_drain(50);
        chk("s3_acks", ack_total - a0, 2);

        // Tag change inside a three-entry packet.
        ready_mode = 2;
        push(2'd1, 1'b0, 1'b0, rnd_pl());
        push(2'd2, 1'b0, 1'b0, rnd_pl());
        push(2'd1, 1'b0, 1'b1, rnd_pl());
        wait_drain(100);
        chk("s4_tid_err", tid_err, 1);

        // FIFO underrun mid-packet.
        ready_mode = 1;
        push(2'd1, 1'b0, 1'b0, rnd_pl());
        wait_drain(50);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s5_gap_valid", out_valid, 0);
        end
        push(2'd1, 1'b0, 1'b1, rnd_pl());
        wait_drain(50);

        // Reset while the HI beat is presented.
        ready_mode = 0;
        pl = rnd_pl();
        push(2'd2, 1'b0, 1'b1, pl);
        wait_valid(20);
        ready_mode = 1;
        tick();
        ready_mode = 0;
        tick();
        chk("s6_hi_data", out_data, pl[127:64]);
        rst = 1'b1;
        #1;
        chk("s6_rst_valid", out_valid, 0);
        chk("s6_rst_pkt_cnt", pkt_cnt, 0);
        chk("s6_rst_tid_err", tid_err, 0);
        m_reset();
        push(2'd3, 1'b1, 1'b1, rnd_pl());
        tick();
        tick();
        chk("s6_rst_ack", fifo_out_ack, 0);
        rst        = 1'b0;
        ready_mode = 1;
        wait_drain(50);
        chk("s6_pkt_cnt", pkt_cnt, 1);

        // Randomised traffic with random backpressure and gaps.
        ready_mode = 2;
        cur_tid    = 2'd0;
        for (int i = 0; i < 200; i++) begin
            if (m_sot) cur_tid = 2'($urandom_range(0, 3));
            else if ($urandom_range(0, 15) == 0) cur_tid = cur_tid + 2'd1;
            push(cur_tid, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), rnd_pl());
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_drain(3000);

        // Counter wrap after a full 2^CNT_W packets.
        rst = 1'b1;
        tick();
        m_reset();
        rst        = 1'b0;
        ready_mode = 1;
        tick();
        for (int i = 0; i < (1 << CNT_W); i++) push(2'd2, 1'b1, 1'b1, rnd_pl());
        wait_drain(70000);
        chk("wrap_pkt_cnt", pkt_cnt, 0);
        chk("wrap_tid_err", tid_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
